button_impulse_gen: RTL and testbench

//  Generates the one-cycle colour-mode advance pulse (impulso) consumed by the colour organiser.

---
 rtl/button_impulse_gen_pkg.sv | 36 +++
 rtl/button_impulse_gen_antirrebote.sv | 55 +++++
 rtl/button_impulse_gen.sv | 106 ++++++++++
 tb/tb_button_impulse_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_impulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// button_impulse_gen_pkg
//   Shared definitions for the push-button impulse generator:
//   - default timing parameters (50 MHz board clock)
//   - default mode-index modulus, shared with the colour organiser case range
//   - FSM state type
//   - helper functions used to size the counters
// -----------------------------------------------------------------------------
package button_impulse_gen_pkg;

    // 20 ms of stable samples at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    // 0.5 s from the press pulse to the first auto-repeat pulse
    localparam int REPEAT_DELAY_DEF    = 25_000_000;
    // 0.2 s between later auto-repeat pulses
    localparam int REPEAT_PERIOD_DEF   = 10_000_000;
    // Number of colour mappings; the colour organiser decodes the same range
    localparam int NUM_MODOS_DEF       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } estado_t;

    // One spare bit above what the largest count needs, so a counter loaded
    // with its maximum value can never wrap.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_impulse_gen_antirrebote.sv
// -----------------------------------------------------------------------------
// button_impulse_gen_antirrebote
//   Synchronises the raw push-button into the clock domain and debounces it.
//   The debounced level follows the synchronised input only after
//   DEBOUNCE_CYCLES consecutive edges on which the two disagree.
//
// Ports
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   boton    in   raw button, asynchronous, active-high, bouncy
//   estable  out  debounced button level
// -----------------------------------------------------------------------------
module button_impulse_gen_antirrebote
    import button_impulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic boton,
    output logic estable
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cnt     <= '0;
            estable <= 1'b0;
        end else begin
            s1 <= boton;
            s2 <= s1;
            // Any agreeing sample restarts the run, so only an unbroken run
            // of DEBOUNCE_CYCLES disagreeing samples moves the output.
            if (s2 != estable) begin
                if (cnt == CNT_LAST) begin
                    estable <= s2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/button_impulse_gen.sv
// -----------------------------------------------------------------------------
// button_impulse_gen
//   Turns a raw board push-button into the one-cycle colour-mode advance pulse
//   (impulso) used by the colour organiser. One pulse per press, plus
//   optional auto-repeat while the button stays held. A shadow copy of the
//   mode index (modo) is kept for status LEDs and the 7-segment display.
//
// Ports
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   boton      in   raw button, asynchronous, active-high, bouncy
//   repeat_en  in   1 = auto-repeat while held, sampled every cycle
//   impulso    out  registered one-cycle advance pulse
//   estable    out  debounced button level
//   modo       out  shadow mode index, +1 per impulso, wraps to 0
// -----------------------------------------------------------------------------
module button_impulse_gen
    import button_impulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter int NUM_MODOS       = NUM_MODOS_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       boton,
    input  logic       repeat_en,
    output logic       impulso,
    output logic       estable,
    output logic [3:0] modo
);

    localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);
    localparam logic [3:0]    MODO_LAST   = 4'(NUM_MODOS - 1);

    estado_t       state;
    estado_t       state_n;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_n;
    logic          estable_q;
    logic          pulso;

    button_impulse_gen_antirrebote #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_antirrebote (
        .clock   (clock),
        .reset_n (reset_n),
        .boton   (boton),
        .estable (estable)
    );

    always_comb begin
        state_n   = state;
        rep_cnt_n = rep_cnt;
        pulso     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (estable && !estable_q) begin
                    pulso     = 1'b1;
                    rep_cnt_n = DELAY_LOAD;
                    state_n   = ST_HELD;
                end
            end
            ST_HELD, ST_REPEAT: begin
                // With repeat_en low the countdown simply freezes, so
                // re-enabling resumes where it left off.
                if (!estable) begin
                    state_n = ST_IDLE;
                end else if (repeat_en) begin
                    if (rep_cnt == '0) begin
                        pulso     = 1'b1;
                        rep_cnt_n = PERIOD_LOAD;
                        state_n   = ST_REPEAT;
                    end else begin
                        rep_cnt_n = rep_cnt - RW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rep_cnt   <= '0;
            estable_q <= 1'b0;
            impulso   <= 1'b0;
            modo      <= '0;
        end else begin
            state     <= state_n;
            rep_cnt   <= rep_cnt_n;
            estable_q <= estable;
            impulso   <= pulso;
            if (pulso) begin
                modo <= (modo == MODO_LAST) ? 4'd0 : modo + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_button_impulse_gen.sv
module tb_button_impulse_gen;

    localparam int D   = 4;
    localparam int DEL = 10;
    localparam int PER = 3;
    localparam int NM  = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       boton;
    logic       repeat_en;
    logic       impulso;
    logic       estable;
    logic [3:0] modo;

    always #5 clock = ~clock;

    button_impulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (DEL),
        .REPEAT_PERIOD   (PER),
        .NUM_MODOS       (NM)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .boton     (boton),
        .repeat_en (repeat_en),
        .impulso   (impulso),
        .estable   (estable),
        .modo      (modo)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int modo;
    } pulso_t;
    pulso_t sb[$];

    // Reference model: button history, debounced level, hold bookkeeping
    int   seen_q[$];
    logic m_est;
    logic m_est_prev;
    int   mism;
    bit   holding;
    int   e_cnt;
    int   m_modo;
    bit   in_reset;
    bit   checking = 0;
    bit   prev_imp = 0;
    int   pulse_count = 0;
    int   last_pulse_cyc = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        seen_q     = '{0, 0};
        m_est      = 1'b0;
        m_est_prev = 1'b0;
        mism       = 0;
        holding    = 0;
        e_cnt      = 0;
        m_modo     = 0;
    endfunction

    // One clock edge of the specified behaviour. The button reaches the
    // debouncer two edges late; pulses are derived from the number of
    // enabled held edges since the press pulse.
    function automatic void model_edge(input logic b, input logic re);
        int   seen;
        logic est_old;
        logic est_prev_old;
        bit   pulse;
        est_old      = m_est;
        est_prev_old = m_est_prev;
        pulse        = 0;
        seen = seen_q.pop_front();
        seen_q.push_back(int'(b));
        if (seen != int'(m_est)) begin
            mism++;
            if (mism == D) begin
                m_est = (seen != 0);
                mism  = 0;
            end
        end else begin
            mism = 0;
        end
        m_est_prev = est_old;
        if (est_old && !est_prev_old) begin
            pulse   = 1;
            holding = 1;
            e_cnt   = 0;
        end else if (holding && !est_old) begin
            holding = 0;
        end else if (holding && re) begin
            e_cnt++;
            if (e_cnt >= DEL && ((e_cnt - DEL) % PER) == 0) pulse = 1;
        end
        if (pulse) begin
            m_modo = (m_modo + 1) % NM;
            sb.push_back('{cyc, m_modo});
        end
    endfunction

    task automatic step(input logic b, input logic re);
        boton     = b;
        repeat_en = re;
        @(posedge clock);
        cyc++;
        if (in_reset) model_reset();
        else model_edge(b, re);
        @(negedge clock);
    endtask

    task automatic steps(input int n, input logic b, input logic re);
        for (int i = 0; i < n; i++) step(b, re);
    endtask

    task automatic clean_reset();
        #1;
        reset_n  = 1'b0;
        in_reset = 1;
        model_reset();
        steps(2, 1'b0, 1'b0);
        #1;
        reset_n  = 1'b1;
        in_reset = 0;
    endtask

    // Monitor: compares the DUT against the model and the pulse scoreboard
    always @(negedge clock) begin
        if (checking) begin
            chk("estable", int'(estable), int'(m_est));
            chk("modo", int'(modo), m_modo);
            if (impulso) begin
                pulso_t p;
                chk("impulso_not_adjacent", int'(prev_imp), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_impulso", 1, 0);
                end else begin
                    p = sb.pop_front();
                    chk("impulso_cycle", cyc, p.cyc);
                    chk("impulso_modo", int'(modo), p.modo);
                end
                pulse_count++;
                last_pulse_cyc = cyc;
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                chk("missing_impulso", 0, 1);
                void'(sb.pop_front());
            end
            prev_imp = impulso;
        end
    end

    initial begin
        int c0;
        int pc0;
        reset_n   = 1'b0;
        boton     = 1'b0;
        repeat_en = 1'b0;
        in_reset  = 1;
        model_reset();
        steps(2, 1'b0, 1'b0);
        #1;
        chk("reset_impulso", int'(impulso), 0);
        chk("reset_estable", int'(estable), 0);
        chk("reset_modo", int'(modo), 0);
        reset_n  = 1'b1;
        in_reset = 0;
        checking = 1;

        // Clean press, no repeat: one pulse after edge 7
        c0 = cyc; pc0 = pulse_count;
        steps(8, 1'b1, 1'b0);
        steps(12, 1'b0, 1'b0);
        #1;
        chk("t1_pulse_edge", last_pulse_cyc, c0 + 7);
        chk("t1_pulse_count", pulse_count - pc0, 1);

        // Bounce then steady press
        c0 = cyc; pc0 = pulse_count;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        steps(12, 1'b1, 1'b0);
        steps(12, 1'b0, 1'b0);
        #1;
        chk("t2_pulse_edge", last_pulse_cyc, c0 + 11);
        chk("t2_pulse_count", pulse_count - pc0, 1);

        // 3-cycle glitch from idle
        pc0 = pulse_count;
        steps(3, 1'b1, 1'b0);
        steps(10, 1'b0, 1'b0);
        #1;
        chk("t2_glitch_count", pulse_count - pc0, 0);

        // Long hold with auto-repeat
        steps(40, 1'b1, 1'b1);
        steps(12, 1'b0, 1'b1);

        // repeat_en frozen mid-hold, then resumed
        steps(11, 1'b1, 1'b1);
        steps(20, 1'b1, 1'b0);
        c0 = cyc;
        steps(8, 1'b1, 1'b1);
        #1;
        chk("t4_resume_edge", last_pulse_cyc, c0 + 6);
        steps(12, 1'b0, 1'b0);

        // Asynchronous reset during REPEAT with the button still held
        steps(25, 1'b1, 1'b1);
        #2;
        reset_n  = 1'b0;
        in_reset = 1;
        model_reset();
        #1;
        chk("t5_async_impulso", int'(impulso), 0);
        chk("t5_async_estable", int'(estable), 0);
        chk("t5_async_modo", int'(modo), 0);
        steps(3, 1'b1, 1'b0);
        #1;
        reset_n  = 1'b1;
        in_reset = 0;
        c0 = cyc;
        steps(10, 1'b1, 1'b0);
        #1;
        chk("t5_release_edge", last_pulse_cyc, c0 + 7);
        steps(12, 1'b0, 1'b0);

        // Eight quick press/release pairs from a fresh reset
        clean_reset();
        pc0 = pulse_count;
        for (int i = 0; i < 8; i++) begin
            steps($urandom_range(5, 9), 1'b1, 1'b0);
            steps($urandom_range(5, 9), 1'b0, 1'b0);
        end
        steps(10, 1'b0, 1'b0);
        #1;
        chk("t6_pulse_count", pulse_count - pc0, 8);
        chk("t6_modo_final", int'(modo), 0);

        // Random button runs with random repeat enable
        for (int r = 0; r < 40; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) step(lvl, 1'($urandom_range(0, 1)));
        end
        steps(30, 1'b0, 1'b0);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
